// File: rtl/enigma_step_ctrl.sv
//------------------------------------------------------------------------------
// enigma_step_ctrl : Enigma keypress sequencer. Steps the three rotors (with
// the middle-rotor double-step), waits for the rotor chain to settle, then
// delivers the encrypted letter over a valid/ready handshake.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module enigma_step_ctrl #(
  parameter logic [4:0] NOTCH_F       = 5'd16,
  parameter logic [4:0] NOTCH_M       = 5'd4,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic        key_ready,
  input  logic        load_en,
  input  logic [4:0]  load_f,
  input  logic [4:0]  load_m,
  input  logic [4:0]  load_s,
  output logic [4:0]  pos_f,
  output logic [4:0]  pos_m,
  output logic [4:0]  pos_s,
  output logic [4:0]  path_in,
  input  logic [4:0]  path_out,
  output logic        char_valid,
  output logic [4:0]  char_out,
  input  logic        char_ready,
  output logic        err,
  output logic [15:0] char_count
);

  localparam int             CW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  c_last_cnt = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_started;
  logic [CW-1:0]   r_settle_cnt;
  logic [4:0]      r_pos_f, r_pos_m, r_pos_s;
  logic [4:0]      r_path_in;
  logic [4:0]      r_char_out;
  logic            r_char_valid;
  logic            r_err;
  logic [15:0]     r_char_count;

  logic            w_key_ready;
  logic            w_accept;
  logic            w_key_ok;
  logic            w_path_ok;
  logic            w_settle_done;
  logic            w_deliver;
  logic            w_carry_m;
  logic            w_carry_s;

  function automatic logic [4:0] f_inc(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] f_mod26(input logic [4:0] v);
    return (v > 5'd25) ? v - 5'd26 : v;
  endfunction

  // r_started keeps key_ready low until the first edge after reset release
  assign w_key_ready   = r_started && (r_state == IDLE) && !load_en;
  assign w_accept      = key_valid && w_key_ready;
  assign w_key_ok      = (key_code != 5'd0) && (key_code <= 5'd26);
  assign w_path_ok     = (path_out != 5'd0) && (path_out <= 5'd26);
  assign w_settle_done = (r_state == SETTLE) && (r_settle_cnt == c_last_cnt);
  assign w_deliver     = (r_state == HOLD) && r_char_valid && char_ready;
  assign w_carry_m     = (r_pos_f == NOTCH_F) || (r_pos_m == NOTCH_M);
  assign w_carry_s     = (r_pos_m == NOTCH_M);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_key_ok) w_next = SETTLE;
      SETTLE:  if (w_settle_done)        w_next = HOLD;
      HOLD:    if (w_deliver)            w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started    <= 1'b0;
      r_settle_cnt <= '0;
      r_pos_f      <= 5'd0;
      r_pos_m      <= 5'd0;
      r_pos_s      <= 5'd0;
      r_path_in    <= 5'd0;
      r_char_out   <= 5'd0;
      r_char_valid <= 1'b0;
      r_err        <= 1'b0;
      r_char_count <= 16'd0;
    end else begin
      r_started <= 1'b1;
      r_err     <= (w_accept && !w_key_ok) || (w_settle_done && !w_path_ok);

      if (r_state == IDLE && load_en) begin
        r_pos_f <= f_mod26(load_f);
        r_pos_m <= f_mod26(load_m);
        r_pos_s <= f_mod26(load_s);
      end else if (w_accept && w_key_ok) begin
        r_path_in    <= key_code;
        r_settle_cnt <= '0;
        r_pos_f      <= f_inc(r_pos_f);
        if (w_carry_m) r_pos_m <= f_inc(r_pos_m);
        if (w_carry_s) r_pos_s <= f_inc(r_pos_s);
      end

      if (r_state == SETTLE && !w_settle_done) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end

      if (w_settle_done) begin
        r_char_out   <= path_out;
        r_char_valid <= 1'b1;
      end else if (w_deliver) begin
        r_char_valid <= 1'b0;
        if (r_char_count != 16'hFFFF) r_char_count <= r_char_count + 16'd1;
      end
    end
  end

  assign key_ready  = w_key_ready;
  assign pos_f      = r_pos_f;
  assign pos_m      = r_pos_m;
  assign pos_s      = r_pos_s;
  assign path_in    = r_path_in;
  assign char_valid = r_char_valid;
  assign char_out   = r_char_out;
  assign err        = r_err;
  assign char_count = r_char_count;

endmodule

`default_nettype wire

// File: tb/tb_enigma_step_ctrl.sv
//------------------------------------------------------------------------------
// tb_enigma_step_ctrl : directed bench for enigma_step_ctrl (default notches
// plus a second instance with both notches at 25).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_enigma_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid, load_en, char_ready;
  logic [4:0]  key_code, load_f, load_m, load_s, path_out;

  logic        key_ready, char_valid, err;
  logic [4:0]  pos_f, pos_m, pos_s, path_in, char_out;
  logic [15:0] char_count;

  logic        key_ready2, char_valid2, err2;
  logic [4:0]  pos_f2, pos_m2, pos_s2, path_in2, char_out2;
  logic [15:0] char_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  enigma_step_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .load_en(load_en), .load_f(load_f), .load_m(load_m), .load_s(load_s),
    .pos_f(pos_f), .pos_m(pos_m), .pos_s(pos_s),
    .path_in(path_in), .path_out(path_out),
    .char_valid(char_valid), .char_out(char_out), .char_ready(char_ready),
    .err(err), .char_count(char_count)
  );

  enigma_step_ctrl #(.NOTCH_F(5'd25), .NOTCH_M(5'd25), .SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready2),
    .load_en(load_en), .load_f(load_f), .load_m(load_m), .load_s(load_s),
    .pos_f(pos_f2), .pos_m(pos_m2), .pos_s(pos_s2),
    .path_in(path_in2), .path_out(path_out),
    .char_valid(char_valid2), .char_out(char_out2), .char_ready(char_ready),
    .err(err2), .char_count(char_count2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag, input logic [4:0] f, input logic [4:0] m,
                           input logic [4:0] s);
    check_eq({tag, ".f"}, {27'd0, pos_f}, {27'd0, f});
    check_eq({tag, ".m"}, {27'd0, pos_m}, {27'd0, m});
    check_eq({tag, ".s"}, {27'd0, pos_s}, {27'd0, s});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] f, input logic [4:0] m, input logic [4:0] s);
    load_en = 1'b1; load_f = f; load_m = m; load_s = s;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_key(input logic [4:0] code);
    key_valid = 1'b1; key_code = code;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic handshake();
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_code = 5'd0; load_en = 1'b0;
    load_f = 5'd0; load_m = 5'd0; load_s = 5'd0; path_out = 5'd0; char_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_pos("rst_pos", 5'd0, 5'd0, 5'd0);
    check_eq("rst_key_ready", {31'd0, key_ready}, 32'd0);
    check_eq("rst_char_valid", {31'd0, char_valid}, 32'd0);
    check_eq("rst_count", {16'd0, char_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_key_ready_pre", {31'd0, key_ready}, 32'd0);
    tick();
    check_eq("rel_key_ready_post", {31'd0, key_ready}, 32'd1);

    // basic letter
    do_load(5'd0, 5'd0, 5'd0);
    check_pos("load0", 5'd0, 5'd0, 5'd0);
    path_out = 5'd7;
    do_key(5'd1);
    check_pos("key1", 5'd1, 5'd0, 5'd0);
    check_eq("key1_path_in", {27'd0, path_in}, 32'd1);
    check_eq("key1_cv_T", {31'd0, char_valid}, 32'd0);
    tick();
    check_eq("key1_cv_T1", {31'd0, char_valid}, 32'd0);
    tick();
    check_eq("key1_cv_T2", {31'd0, char_valid}, 32'd1);
    check_eq("key1_char", {27'd0, char_out}, 32'd7);
    handshake();
    check_eq("key1_cv_after", {31'd0, char_valid}, 32'd0);
    check_eq("key1_count", {16'd0, char_count}, 32'd1);
    check_eq("key1_ready_after", {31'd0, key_ready}, 32'd1);

    // fast-rotor carry then middle double-step
    do_load(5'd16, 5'd3, 5'd7);
    path_out = 5'd12;
    do_key(5'd5);
    check_pos("dbl1", 5'd17, 5'd4, 5'd7);
    tick(); tick();
    check_eq("dbl1_char", {27'd0, char_out}, 32'd12);
    handshake();
    do_key(5'd6);
    check_pos("dbl2", 5'd18, 5'd5, 5'd8);
    check_eq("dbl2_path_in", {27'd0, path_in}, 32'd6);
    tick(); tick();
    handshake();
    check_eq("dbl_count", {16'd0, char_count}, 32'd3);

    // wrap at 25 on both instances
    do_load(5'd25, 5'd25, 5'd25);
    do_key(5'd2);
    check_eq("wrap2.f", {27'd0, pos_f2}, 32'd0);
    check_eq("wrap2.m", {27'd0, pos_m2}, 32'd0);
    check_eq("wrap2.s", {27'd0, pos_s2}, 32'd0);
    check_pos("wrap1", 5'd0, 5'd25, 5'd25);
    tick(); tick();
    handshake();
    do_load(5'd30, 5'd26, 5'd31);
    check_pos("load_mod", 5'd4, 5'd0, 5'd5);

    // invalid key codes
    key_valid = 1'b1; key_code = 5'd0;
    tick();
    check_eq("bad0_err", {31'd0, err}, 32'd1);
    check_pos("bad0_pos", 5'd4, 5'd0, 5'd5);
    key_code = 5'd27;
    tick();
    check_eq("bad27_err", {31'd0, err}, 32'd1);
    key_valid = 1'b0;
    tick();
    check_eq("bad_err_clear", {31'd0, err}, 32'd0);
    check_eq("bad_cv", {31'd0, char_valid}, 32'd0);
    check_pos("bad_pos", 5'd4, 5'd0, 5'd5);

    // invalid path_out captured
    path_out = 5'd0;
    do_key(5'd3);
    check_pos("badpath_pos", 5'd5, 5'd0, 5'd5);
    check_eq("badpath_err_T", {31'd0, err}, 32'd0);
    tick();
    check_eq("badpath_err_T1", {31'd0, err}, 32'd0);
    tick();
    check_eq("badpath_cv", {31'd0, char_valid}, 32'd1);
    check_eq("badpath_char", {27'd0, char_out}, 32'd0);
    check_eq("badpath_err", {31'd0, err}, 32'd1);
    tick();
    check_eq("badpath_err_clear", {31'd0, err}, 32'd0);
    check_eq("badpath_cv_hold", {31'd0, char_valid}, 32'd1);
    handshake();

    // backpressure with key_valid held and load_en ignored in HOLD
    path_out = 5'd20;
    key_valid = 1'b1; key_code = 5'd4;
    tick();
    check_pos("bp_step", 5'd6, 5'd0, 5'd5);
    tick(); tick();
    check_eq("bp_cv", {31'd0, char_valid}, 32'd1);
    path_out = 5'd9;
    load_en = 1'b1; load_f = 5'd1; load_m = 5'd1; load_s = 5'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_char", {27'd0, char_out}, 32'd20);
      check_eq("bp_ready", {31'd0, key_ready}, 32'd0);
      check_eq("bp_pos_f", {27'd0, pos_f}, 32'd6);
    end
    load_en = 1'b0; key_valid = 1'b0;
    handshake();
    check_eq("bp_cv_after", {31'd0, char_valid}, 32'd0);
    check_pos("bp_pos_after", 5'd6, 5'd0, 5'd5);

    // load wins over key in IDLE
    load_en = 1'b1; load_f = 5'd10; load_m = 5'd11; load_s = 5'd12;
    key_valid = 1'b1; key_code = 5'd5;
    #1;
    check_eq("ld_key_ready", {31'd0, key_ready}, 32'd0);
    tick();
    load_en = 1'b0; key_valid = 1'b0;
    check_pos("ld_key_pos", 5'd10, 5'd11, 5'd12);
    check_eq("ld_key_path_in", {27'd0, path_in}, 32'd4);
    tick(); tick();
    check_eq("ld_key_cv", {31'd0, char_valid}, 32'd0);

    // reset mid-SETTLE
    do_key(5'd1);
    check_pos("pre_rst", 5'd11, 5'd11, 5'd12);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_pos("mid_rst", 5'd0, 5'd0, 5'd0);
    check_eq("mid_rst_cv", {31'd0, char_valid}, 32'd0);
    check_eq("mid_rst_path_in", {27'd0, path_in}, 32'd0);
    check_eq("mid_rst_count", {16'd0, char_count}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, key_ready}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check_eq("rst2_ready_pre", {31'd0, key_ready}, 32'd0);
    tick();
    check_eq("rst2_ready_post", {31'd0, key_ready}, 32'd1);
    tick(); tick();
    check_eq("rst2_cv", {31'd0, char_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
